// File: rtl/cook_timer_pkg.sv
// Shared types and constants for the cook_timer countdown stage.
package cook_timer_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        StIdle,
        StCooking,
        StPaused,
        StDone
    } state_t;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } mmss_t;

    localparam bcd_t        BCD_NINE      = 4'd9;
    localparam bcd_t        BCD_FIVE      = 4'd5;
    localparam int unsigned QUICK_SECONDS = 30;

endpackage

// File: rtl/cook_timer_if.sv
// Control inputs and display/status outputs of cook_timer.
interface cook_timer_if;
    import cook_timer_pkg::*;

    logic hz1;
    logic key_valid;
    bcd_t key_digit;
    logic start;
    logic stop;
    logic door_open;
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
    logic magnetron_on;
    logic done_beep;
    logic cooking;

    modport master (
        output hz1, key_valid, key_digit, start, stop, door_open,
        input  min_tens, min_ones, sec_tens, sec_ones, magnetron_on, done_beep, cooking
    );

    modport slave (
        input  hz1, key_valid, key_digit, start, stop, door_open,
        output min_tens, min_ones, sec_tens, sec_ones, magnetron_on, done_beep, cooking
    );

endinterface

// File: rtl/bcd_mmss_dec.sv
// Combinational MM:SS BCD decrement with zero flag; the +30 s saturating add
// exists only when QUICK_START_EN is defined.
module bcd_mmss_dec
    import cook_timer_pkg::*;
(
    input  mmss_t cur,
    output mmss_t dec,
    output logic  zero
`ifdef QUICK_START_EN
    ,
    output mmss_t add30
`endif
);

    assign zero = (cur == '0);

    always_comb begin
        dec = cur;
        if (cur.sec_ones != '0) begin
            dec.sec_ones = cur.sec_ones - 4'd1;
        end else if (cur.sec_tens != '0) begin
            dec.sec_tens = cur.sec_tens - 4'd1;
            dec.sec_ones = BCD_NINE;
        end else if (cur.min_ones != '0) begin
            dec.min_ones = cur.min_ones - 4'd1;
            dec.sec_tens = BCD_FIVE;
            dec.sec_ones = BCD_NINE;
        end else if (cur.min_tens != '0) begin
            dec.min_tens = cur.min_tens - 4'd1;
            dec.min_ones = BCD_NINE;
            dec.sec_tens = BCD_FIVE;
            dec.sec_ones = BCD_NINE;
        end
    end

`ifdef QUICK_START_EN
    logic [7:0] secs;
    logic [7:0] mins;

    // Seconds may exceed 59 (e.g. 00:99), so normalise in binary before re-encoding.
    always_comb begin
        secs = 8'(cur.sec_tens) * 8'd10 + 8'(cur.sec_ones) + 8'(QUICK_SECONDS);
        mins = 8'(cur.min_tens) * 8'd10 + 8'(cur.min_ones);
        if (secs >= 8'd120) begin
            secs = secs - 8'd120;
            mins = mins + 8'd2;
        end else if (secs >= 8'd60) begin
            secs = secs - 8'd60;
            mins = mins + 8'd1;
        end
        if (mins > 8'd99) begin
            add30 = '{min_tens: BCD_NINE, min_ones: BCD_NINE,
                      sec_tens: BCD_FIVE, sec_ones: BCD_NINE};
        end else begin
            add30.min_tens = 4'(mins / 8'd10);
            add30.min_ones = 4'(mins % 8'd10);
            add30.sec_tens = 4'(secs / 8'd10);
            add30.sec_ones = 4'(secs % 8'd10);
        end
    end
`endif

endmodule

// File: rtl/cook_timer.sv
// Microwave cooking-time countdown: BCD time entry, 1 Hz countdown, pause and beep.
// Optional QUICK_START_EN: start at 00:00 loads 00:30, start while cooking adds 30 s.
module cook_timer
    import cook_timer_pkg::*;
#(
    parameter int unsigned BEEP_SECONDS = 3
) (
    input  logic         clk_100Hz,
    input  logic         rst_n,
    cook_timer_if.slave  bus
);

    state_t     state_q, state_d;
    mmss_t      time_q, time_d;
    logic [3:0] beep_q, beep_d;
    logic       hz1_d;
    logic       tick;
    mmss_t      dec_time;
    logic       time_zero;
`ifdef QUICK_START_EN
    mmss_t      add_time;
`endif

    localparam mmss_t ONE_SECOND = '{min_tens: 4'd0, min_ones: 4'd0,
                                     sec_tens: 4'd0, sec_ones: 4'd1};

    assign tick = bus.hz1 & ~hz1_d;

    bcd_mmss_dec u_dec (
        .cur   (time_q),
        .dec   (dec_time),
        .zero  (time_zero)
`ifdef QUICK_START_EN
        ,
        .add30 (add_time)
`endif
    );

    always_ff @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            time_q  <= '0;
            beep_q  <= '0;
            hz1_d   <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            beep_q  <= beep_d;
            hz1_d   <= bus.hz1;
        end
    end

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        beep_d  = beep_q;
        unique case (state_q)
            StIdle: begin
                if (bus.stop) begin
                    time_d = '0;
                end else if (bus.start) begin
                    if (!bus.door_open) begin
                        if (!time_zero) begin
                            state_d = StCooking;
                        end
`ifdef QUICK_START_EN
                        else begin
                            time_d  = add_time;
                            state_d = StCooking;
                        end
`endif
                    end
                end else if (bus.key_valid && bus.key_digit <= BCD_NINE) begin
                    time_d = '{min_tens: time_q.min_ones, min_ones: time_q.sec_tens,
                               sec_tens: time_q.sec_ones, sec_ones: bus.key_digit};
                end
            end
            StCooking: begin
                if (bus.door_open || bus.stop) begin
                    state_d = StPaused;
                end
`ifdef QUICK_START_EN
                else if (bus.start) begin
                    time_d = add_time;
                end
`endif
                else if (tick) begin
                    time_d = dec_time;
                    if (time_q == ONE_SECOND) begin
                        state_d = StDone;
                        beep_d  = '0;
                    end
                end
            end
            StPaused: begin
                if (bus.stop) begin
                    state_d = StIdle;
                    time_d  = '0;
                end else if (bus.start && !bus.door_open) begin
                    state_d = StCooking;
                end
            end
            StDone: begin
                if (bus.door_open || bus.stop) begin
                    state_d = StIdle;
                    beep_d  = '0;
                end else if (tick) begin
                    if (beep_q == 4'(BEEP_SECONDS - 1)) begin
                        state_d = StIdle;
                        beep_d  = '0;
                    end else begin
                        beep_d = beep_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Door path stays combinational so the magnetron cuts off in the same cycle.
    assign bus.magnetron_on = (state_q == StCooking) & ~bus.door_open;
    assign bus.cooking      = (state_q == StCooking);
    assign bus.done_beep    = (state_q == StDone);
    assign bus.min_tens     = time_q.min_tens;
    assign bus.min_ones     = time_q.min_ones;
    assign bus.sec_tens     = time_q.sec_tens;
    assign bus.sec_ones     = time_q.sec_ones;

endmodule

// File: tb/tb_cook_timer.sv
// Self-checking bench for cook_timer; expectations are queued with each stimulus
// and drained against the sampled outputs.
module tb_cook_timer;

    logic clk_100Hz = 1'b0;
    logic rst_n     = 1'b0;

    cook_timer_if bus ();

    cook_timer #(
        .BEEP_SECONDS (3)
    ) dut (
        .clk_100Hz (clk_100Hz),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #5 clk_100Hz = ~clk_100Hz;

    typedef struct {
        string       tag;
        logic [15:0] mmss;
        logic        ck;
        logic        bp;
        logic        mg;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [15:0] mmss,
                              input logic ck, input logic bp, input logic mg);
        exp_t e;
        e.tag = tag; e.mmss = mmss; e.ck = ck; e.bp = bp; e.mg = mg;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val({e.tag, "_time"},
                      {16'h0, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones},
                      {16'h0, e.mmss});
            check_val({e.tag, "_cooking"}, {31'h0, bus.cooking}, {31'h0, e.ck});
            check_val({e.tag, "_beep"}, {31'h0, bus.done_beep}, {31'h0, e.bp});
            check_val({e.tag, "_magnetron"}, {31'h0, bus.magnetron_on}, {31'h0, e.mg});
        end
    endtask

    task automatic step();
        @(posedge clk_100Hz);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        bus.key_valid = 1'b1;
        bus.key_digit = d;
        step();
        bus.key_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    task automatic tick();
        bus.hz1 = 1'b1;
        step();
        bus.hz1 = 1'b0;
        step();
    endtask

    initial begin
        bus.hz1 = 1'b0; bus.key_valid = 1'b0; bus.key_digit = 4'd0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.door_open = 1'b0;
        repeat (2) step();
        expect_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        compare_out();
        #2 rst_n = 1'b1;
        step();

        press(4'd1); press(4'd3); press(4'd0);
        expect_out("entry_130", 16'h0130, 1'b0, 1'b0, 1'b0);
        compare_out();
        pulse_start();
        expect_out("start_130", 16'h0130, 1'b1, 1'b0, 1'b1);
        compare_out();
        repeat (3) tick();
        expect_out("cook_127", 16'h0127, 1'b1, 1'b0, 1'b1);
        compare_out();
        repeat (58) tick();
        expect_out("cook_029", 16'h0029, 1'b1, 1'b0, 1'b1);
        compare_out();
`ifndef QUICK_START_EN
        pulse_start();
        expect_out("start_in_cook_ignored", 16'h0029, 1'b1, 1'b0, 1'b1);
        compare_out();
`endif
        pulse_stop();
        expect_out("pause_029", 16'h0029, 1'b0, 1'b0, 1'b0);
        compare_out();
        pulse_stop();
        expect_out("clear", 16'h0000, 1'b0, 1'b0, 1'b0);
        compare_out();
`ifndef QUICK_START_EN
        pulse_start();
        expect_out("start_zero_ignored", 16'h0000, 1'b0, 1'b0, 1'b0);
        compare_out();
`endif

        // Countdown to DONE and the beep period
        press(4'd0); press(4'd2);
        pulse_start();
        expect_out("start_002", 16'h0002, 1'b1, 1'b0, 1'b1);
        compare_out();
        tick();
        expect_out("cook_001", 16'h0001, 1'b1, 1'b0, 1'b1);
        compare_out();
        tick();
        expect_out("done", 16'h0000, 1'b0, 1'b1, 1'b0);
        compare_out();
        tick(); tick();
        expect_out("beep_held", 16'h0000, 1'b0, 1'b1, 1'b0);
        compare_out();
        tick();
        expect_out("beep_end", 16'h0000, 1'b0, 1'b0, 1'b0);
        compare_out();

        // Door opened coincident with a tick
        press(4'd5); press(4'd0); press(4'd0);
        pulse_start();
        expect_out("start_500", 16'h0500, 1'b1, 1'b0, 1'b1);
        compare_out();
        bus.door_open = 1'b1;
        bus.hz1 = 1'b1;
        #1;
        check_val("magnetron_door_comb", {31'h0, bus.magnetron_on}, 32'h0);
        step();
        bus.hz1 = 1'b0;
        expect_out("door_pause", 16'h0500, 1'b0, 1'b0, 1'b0);
        compare_out();
        bus.door_open = 1'b0;
        step();
        tick();
        expect_out("door_closed_paused", 16'h0500, 1'b0, 1'b0, 1'b0);
        compare_out();
        pulse_start();
        expect_out("resume_500", 16'h0500, 1'b1, 1'b0, 1'b1);
        compare_out();
        tick();
        expect_out("cook_459", 16'h0459, 1'b1, 1'b0, 1'b1);
        compare_out();
        pulse_stop(); pulse_stop();

        // Pause at 00:45, cancel, then reject an out-of-range digit
        press(4'd4); press(4'd5);
        pulse_start();
        pulse_stop();
        expect_out("pause_045", 16'h0045, 1'b0, 1'b0, 1'b0);
        compare_out();
        pulse_stop();
        expect_out("cancel_045", 16'h0000, 1'b0, 1'b0, 1'b0);
        compare_out();
        press(4'd7);
        press(4'd12);
        expect_out("bad_digit", 16'h0007, 1'b0, 1'b0, 1'b0);
        compare_out();
        pulse_stop();

        // 00:99 is a legal entry
        press(4'd9); press(4'd9);
        pulse_start();
        tick();
        expect_out("cook_098", 16'h0098, 1'b1, 1'b0, 1'b1);
        compare_out();
        pulse_stop(); pulse_stop();

        // Asynchronous reset mid-cook
        press(4'd3); press(4'd1); press(4'd0);
        pulse_start();
        expect_out("start_310", 16'h0310, 1'b1, 1'b0, 1'b1);
        compare_out();
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        compare_out();
        #3 rst_n = 1'b1;
        step();
        expect_out("after_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        compare_out();

`ifdef QUICK_START_EN
        pulse_start();
        expect_out("quick_030", 16'h0030, 1'b1, 1'b0, 1'b1);
        compare_out();
        pulse_stop(); pulse_stop();
        press(4'd9); press(4'd9); press(4'd4); press(4'd5);
        pulse_start();
        expect_out("start_9945", 16'h9945, 1'b1, 1'b0, 1'b1);
        compare_out();
        pulse_start();
        expect_out("quick_sat", 16'h9959, 1'b1, 1'b0, 1'b1);
        compare_out();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
